// File: rtl/result_averager_if.sv
// Result channel of the averager: held result, range tag, window min/max and valid/ready.
// master = averager side, slave = consumer side (SPI TX path or debug logic).
interface result_averager_if #(
   parameter int CNT_W = 16
);
   logic signed [CNT_W:0] result_o;
   logic [2:0]            result_range_o;
   logic                  result_valid_o;
   logic                  result_ready_i;
   logic signed [CNT_W:0] min_o;
   logic signed [CNT_W:0] max_o;

   modport master (
      output result_o, result_range_o, result_valid_o, min_o, max_o,
      input  result_ready_i
   );

   modport slave (
      input  result_o, result_range_o, result_valid_o, min_o, max_o,
      output result_ready_i
   );
endinterface

// File: rtl/result_averager.sv
// Averages 2^K signed conversion samples per window and presents each result on a valid/ready hold register.
// Optional macro RESULT_MINMAX_EN adds per-window signed min/max tracking on min_o/max_o.
module result_averager #(
   parameter int CNT_W    = 16,
   parameter int MAX_LOG2 = 7
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             sample_valid_i,
   input  logic [CNT_W-1:0] count_i,
   input  logic             sign_i,
   input  logic [2:0]       range_i,
   input  logic             range_err_i,
   input  logic [2:0]       avg_log2_i,
   input  logic             clear_i,
   output logic [7:0]       fill_o,
   output logic             overrun_o,
   output logic             err_o,
   result_averager_if.master res
);

   localparam int ACC_W = CNT_W + 1 + MAX_LOG2;

   typedef enum logic {EMPTY, ACCUM} state_t;

   state_t                state_q, state_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic [7:0]            fill_q, fill_d;
   logic [2:0]            k_q, k_d;
   logic [2:0]            winRange_q, winRange_d;
   logic signed [CNT_W:0] result_q, result_d;
   logic [2:0]            resRange_q, resRange_d;
   logic                  valid_q, valid_d;
   logic                  overrun_q, overrun_d;
   logic                  err_q, err_d;

   logic signed [CNT_W:0]   sample;
   logic signed [CNT_W:0]   magnitude;
   logic signed [ACC_W-1:0] sampleExt;
   logic signed [ACC_W-1:0] baseAcc;
   logic signed [ACC_W-1:0] accSum;
   logic signed [ACC_W-1:0] shifted;
   logic [7:0]              baseFill;
   logic [7:0]              fillSum;
   logic [2:0]              kClamp;
   logic [2:0]              kUse;
   logic                    accept;
   logic                    startWin;
   logic                    winDone;

   // A new window starts from EMPTY or whenever the range tag differs from the open window.
   always_comb begin
      magnitude = {1'b0, count_i};
      sample    = sign_i ? -magnitude : magnitude;
      sampleExt = {{MAX_LOG2{sample[CNT_W]}}, sample};
      accept    = sample_valid_i & ~range_err_i;
      startWin  = (state_q == EMPTY) | (range_i != winRange_q);
      kClamp    = (32'(avg_log2_i) > MAX_LOG2) ? 3'(MAX_LOG2) : avg_log2_i;
      kUse      = startWin ? kClamp : k_q;
      baseAcc   = startWin ? '0 : acc_q;
      baseFill  = startWin ? 8'd0 : fill_q;
      accSum    = baseAcc + sampleExt;
      fillSum   = baseFill + 8'd1;
      winDone   = accept & (fillSum == (8'd1 << kUse));
      shifted   = accSum >>> kUse;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state_q <= EMPTY;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (clear_i)     state_d = EMPTY;
      else if (accept) state_d = winDone ? EMPTY : ACCUM;
   end

   always_comb begin
      fill_o             = fill_q;
      overrun_o          = overrun_q;
      err_o              = err_q;
      res.result_o       = result_q;
      res.result_range_o = resRange_q;
      res.result_valid_o = valid_q;
   end

   always_comb begin
      acc_d      = acc_q;
      fill_d     = fill_q;
      k_d        = k_q;
      winRange_d = winRange_q;
      result_d   = result_q;
      resRange_d = resRange_q;
      valid_d    = valid_q;
      overrun_d  = overrun_q;
      err_d      = err_q;
      if (clear_i) begin
         acc_d      = '0;
         fill_d     = 8'd0;
         result_d   = '0;
         resRange_d = 3'd0;
         valid_d    = 1'b0;
         overrun_d  = 1'b0;
         err_d      = 1'b0;
      end else begin
         if (sample_valid_i & range_err_i) err_d = 1'b1;
         if (valid_q & res.result_ready_i) valid_d = 1'b0;
         if (accept) begin
            k_d        = kUse;
            winRange_d = range_i;
            if (winDone) begin
               acc_d      = '0;
               fill_d     = 8'd0;
               result_d   = shifted[CNT_W:0];
               resRange_d = range_i;
               valid_d    = 1'b1;
               if (valid_q & ~res.result_ready_i) overrun_d = 1'b1;
            end else begin
               acc_d  = accSum;
               fill_d = fillSum;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         acc_q      <= '0;
         fill_q     <= 8'd0;
         k_q        <= 3'd0;
         winRange_q <= 3'd0;
         result_q   <= '0;
         resRange_q <= 3'd0;
         valid_q    <= 1'b0;
         overrun_q  <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         acc_q      <= acc_d;
         fill_q     <= fill_d;
         k_q        <= k_d;
         winRange_q <= winRange_d;
         result_q   <= result_d;
         resRange_q <= resRange_d;
         valid_q    <= valid_d;
         overrun_q  <= overrun_d;
         err_q      <= err_d;
      end
   end

`ifdef RESULT_MINMAX_EN
   logic signed [CNT_W:0] winMin_q, winMin_d, winMax_q, winMax_d;
   logic signed [CNT_W:0] min_q, min_d, max_q, max_d;
   logic signed [CNT_W:0] newMin, newMax;

   // Window extremes run alongside the accumulator; the visible pair only moves with result_o.
   always_comb begin
      newMin   = startWin ? sample : ((sample < winMin_q) ? sample : winMin_q);
      newMax   = startWin ? sample : ((sample > winMax_q) ? sample : winMax_q);
      winMin_d = winMin_q;
      winMax_d = winMax_q;
      min_d    = min_q;
      max_d    = max_q;
      if (clear_i) begin
         winMin_d = '0;
         winMax_d = '0;
         min_d    = '0;
         max_d    = '0;
      end else if (accept) begin
         winMin_d = newMin;
         winMax_d = newMax;
         if (winDone) begin
            min_d = newMin;
            max_d = newMax;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         winMin_q <= '0;
         winMax_q <= '0;
         min_q    <= '0;
         max_q    <= '0;
      end else begin
         winMin_q <= winMin_d;
         winMax_q <= winMax_d;
         min_q    <= min_d;
         max_q    <= max_d;
      end
   end

   assign res.min_o = min_q;
   assign res.max_o = max_q;
`else
   assign res.min_o = '0;
   assign res.max_o = '0;
`endif

endmodule
